// File: rtl/decim_pkg.sv
// Shared definitions for the multi-channel decimator: reduction mode
// encodings and the two-state control FSM encoding.
package decim_pkg;

  // Reduction applied to each window of samples.
  localparam logic [1:0] MODE_PICK = 2'd0;
  localparam logic [1:0] MODE_AVG  = 2'd1;
  localparam logic [1:0] MODE_MAX  = 2'd2;
  localparam logic [1:0] MODE_MIN  = 2'd3;

  // Control FSM: IDLE flushes everything, RUN accepts samples.
  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE = 1'b0;
  localparam state_t ST_RUN  = 1'b1;

endpackage

// File: rtl/decim_channel.sv
// One decimator channel: running accumulator (sum, max, min or first
// sample) and the registered per-window result.
module decim_channel
  import decim_pkg::*;
#(
  parameter int DATAWIDTH = 14,
  parameter int MAX_LOG2  = 8,
  parameter int SHIFT_W   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 accept,
  input  logic                 first,
  input  logic                 last,
  input  logic [1:0]           mode_sel,
  input  logic [SHIFT_W-1:0]   shift,
  input  logic [DATAWIDTH-1:0] in_sample,
  output logic [DATAWIDTH-1:0] out_sample
);

  // Wide enough to sum 2^MAX_LOG2 full-scale samples without overflow.
  localparam int AW = DATAWIDTH + MAX_LOG2;

  logic signed [AW-1:0]  acc;
  logic signed [AW-1:0]  acc_next;
  logic signed [AW-1:0]  sample_ext;
  logic [DATAWIDTH-1:0]  result_next;

  assign sample_ext = AW'($signed(in_sample));

  // Fold the incoming sample into the window state; the first sample seeds it.
  always_comb begin
    // NOTE: default assignment first so every path drives acc_next and no latch is inferred.
    acc_next = acc;
    if (first) begin
      acc_next = sample_ext;
    end else begin
      case (mode_sel)
        MODE_AVG: acc_next = acc + sample_ext;
        MODE_MAX: if (sample_ext > acc) acc_next = sample_ext;
        MODE_MIN: if (sample_ext < acc) acc_next = sample_ext;
        default:  acc_next = acc;
      endcase
    end
  end

  // Average divides by R with an arithmetic shift (rounds toward -inf);
  // the other modes already hold an in-range sample in the accumulator.
  assign result_next = (mode_sel == MODE_AVG) ? DATAWIDTH'(acc_next >>> shift)
                                              : acc_next[DATAWIDTH-1:0];

  // Accumulator and result registers; disable flushes both.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
      acc        <= '0;
      out_sample <= '0;
    end else if (clear) begin
      acc        <= '0;
      out_sample <= '0;
    end else if (accept) begin
      acc <= acc_next;
      if (last) out_sample <= result_next;
    end
  end

endmodule

// File: rtl/decimator.sv
// Multi-channel power-of-two decimator with pick/average/max/min
// reduction. Holds the FSM, shared window counter and config latch;
// per-channel datapaths live in decim_channel.
module decimator
  import decim_pkg::*;
#(
  parameter int DATAWIDTH = 14,
  parameter int NUM_CH    = 2,
  parameter int MAX_LOG2  = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              ena,
  input  logic                              in_valid,
  input  logic [NUM_CH*DATAWIDTH-1:0]       in_data,
  input  logic [$clog2(MAX_LOG2+1)-1:0]     ratio_log2,
  input  logic [1:0]                        mode,
  output logic                              out_valid,
  output logic [NUM_CH*DATAWIDTH-1:0]       out_data
);

  localparam int RW = $clog2(MAX_LOG2 + 1);
  localparam int CW = (MAX_LOG2 > 0) ? MAX_LOG2 : 1;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [RW-1:0] ratio_q;
  logic [1:0]    mode_q;

  logic          accept;
  logic          first;
  logic          last;
  logic [RW-1:0] ratio_clamp;
  logic [RW-1:0] ratio_eff;
  logic [1:0]    mode_eff;
  logic [CW:0]   win_len;

  // A sample counts only in RUN with ena still high; ena has priority.
  assign accept      = (state == ST_RUN) && ena && in_valid;
  assign first       = (cnt == '0);
  assign ratio_clamp = (ratio_log2 > RW'(MAX_LOG2)) ? RW'(MAX_LOG2) : ratio_log2;

  // The first sample of a window uses live config; later ones the latched copy.
  assign ratio_eff = first ? ratio_clamp : ratio_q;
  assign mode_eff  = first ? mode : mode_q;
  assign win_len   = (CW+1)'(1) << ratio_eff;
  assign last      = ({1'b0, cnt} == (win_len - 1'b1));

  // FSM: RUN while enabled, IDLE otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= ena ? ST_RUN : ST_IDLE;
  end

  // Window counter and config latch; counter wraps straight into the next window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      ratio_q <= '0;
      mode_q  <= MODE_PICK;
    end else if (!ena) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= last ? '0 : cnt + 1'b1;
      if (first) begin
        ratio_q <= ratio_clamp;
        mode_q  <= mode;
      end
    end
  end

  // Single-cycle strobe on the edge that captures the window's last sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_valid <= 1'b0;
    else        out_valid <= ena && accept && last;
  end

  // One datapath per channel, sharing the window control.
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    decim_channel #(
      .DATAWIDTH (DATAWIDTH),
      .MAX_LOG2  (MAX_LOG2),
      .SHIFT_W   (RW)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (!ena),
      .accept     (accept),
      .first      (first),
      .last       (last),
      .mode_sel   (mode_eff),
      .shift      (ratio_eff),
      .in_sample  (in_data[k*DATAWIDTH +: DATAWIDTH]),
      .out_sample (out_data[k*DATAWIDTH +: DATAWIDTH])
    );
  end

endmodule

// File: tb/tb_decimator.sv
// Self-checking bench for decimator: directed scenarios plus random
// traffic, compared every cycle against a window-level reference model.
module tb_decimator;

  localparam int DW = 14;
  localparam int NCH = 2;
  localparam int ML = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              ena;
  logic              in_valid;
  logic [NCH*DW-1:0] in_data;
  logic [3:0]        ratio_log2;
  logic [1:0]        mode;
  logic              out_valid;
  logic [NCH*DW-1:0] out_data;

  int checks = 0;
  int errors = 0;
  int valid_seen = 0;

  int cfg_ratio = 0;
  int cfg_mode = 0;

  // Reference model state: samples of the open window per channel.
  bit m_run = 0;
  int m_len = 1;
  int m_mode = 0;
  int q0[$];
  int q1[$];
  bit e_valid = 0;
  int e0 = 0;
  int e1 = 0;

  decimator #(.DATAWIDTH(DW), .NUM_CH(NCH), .MAX_LOG2(ML)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .ratio_log2 (ratio_log2),
    .mode       (mode),
    .out_valid  (out_valid),
    .out_data   (out_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sx(input int d);
    logic signed [DW-1:0] t;
    t = d[DW-1:0];
    return int'(t);
  endfunction

  function automatic int reduce(input int q[$], input int md);
    int r;
    int len;
    len = q.size();
    r = q[0];
    case (md)
      1: begin
        int sum = 0;
        foreach (q[i]) sum += q[i];
        r = sum / len;
        if (sum < 0 && (sum % len) != 0) r -= 1;
      end
      2: foreach (q[i]) if (q[i] > r) r = q[i];
      3: foreach (q[i]) if (q[i] < r) r = q[i];
      default: r = q[0];
    endcase
    return r;
  endfunction

  task automatic model_reset();
    m_run = 0;
    q0.delete();
    q1.delete();
    e_valid = 0;
    e0 = 0;
    e1 = 0;
  endtask

  task automatic model_update(input bit en, input bit vld, input int d0, input int d1);
    e_valid = 0;
    if (!en) begin
      model_reset();
    end else if (!m_run) begin
      m_run = 1;
    end else if (vld) begin
      if (q0.size() == 0) begin
        m_len  = 1 << ((cfg_ratio > ML) ? ML : cfg_ratio);
        m_mode = cfg_mode;
      end
      q0.push_back(sx(d0));
      q1.push_back(sx(d1));
      if (q0.size() == m_len) begin
        e_valid = 1;
        e0 = reduce(q0, m_mode);
        e1 = reduce(q1, m_mode);
        q0.delete();
        q1.delete();
      end
    end
  endtask

  // One clock: drive at negedge, sample 1 ns after posedge, compare to model.
  task automatic step(input bit en, input bit vld, input int d0, input int d1);
    logic [NCH*DW-1:0] exp_pack;
    @(negedge clk);
    ena        = en;
    in_valid   = vld;
    in_data    = {d1[DW-1:0], d0[DW-1:0]};
    ratio_log2 = cfg_ratio[3:0];
    mode       = cfg_mode[1:0];
    @(posedge clk);
    #1;
    model_update(en, vld, d0, d1);
    exp_pack = {e1[DW-1:0], e0[DW-1:0]};
    check("out_valid", out_valid, e_valid);
    check("out_data", out_data, exp_pack);
    if (out_valid === 1'b1) valid_seen++;
  endtask

  // Flush any open window and enter RUN with no sample accepted yet.
  task automatic restart();
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
  endtask

  initial begin
    int v0;
    int vs;
    logic [DW-1:0] t14;

    rst_n = 1'b0;
    ena = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    ratio_log2 = '0;
    mode = '0;

    // Reset held with random activity: outputs stay cleared.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      ena = 1'($urandom);
      in_valid = 1'($urandom);
      in_data = NCH*DW'($urandom);
      @(posedge clk);
      #1;
      check("reset_valid", out_valid, 1'b0);
      check("reset_data", out_data, '0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Disabled with random valid input: still idle.
    for (int i = 0; i < 6; i++) step(0, 1'($urandom), $urandom, $urandom);

    // Pick, R=4: ch0 ramps up from 0, ch1 ramps down from -1.
    cfg_ratio = 2; cfg_mode = 0;
    restart();
    for (int i = 0; i < 12; i++) begin
      step(1, 1, i, -1 - i);
      if ((i % 4) == 3) begin
        check("pick_strobe", out_valid, 1'b1);
        t14 = DW'(i - 3);
        check("pick_ch0", out_data[DW-1:0], t14);
        t14 = DW'(-(i - 2));
        check("pick_ch1", out_data[2*DW-1:DW], t14);
      end
    end

    // Average, R=8: 1..8 -> 4, -1 x8 -> -1, then full scale without overflow.
    cfg_ratio = 3; cfg_mode = 1;
    restart();
    for (int i = 1; i <= 8; i++) step(1, 1, i, -1);
    check("avg_ramp", out_data[DW-1:0], 14'd4);
    check("avg_neg", out_data[2*DW-1:DW], 14'h3FFF);
    for (int i = 0; i < 8; i++) step(1, 1, 8191, 8191);
    check("avg_fullscale", out_data, {14'd8191, 14'd8191});
    for (int i = 0; i < 8; i++) step(1, 1, $urandom, $urandom);

    // Max then min, R=4, with random in_valid gaps between samples.
    for (int md = 2; md <= 3; md++) begin
      int seq[4] = '{5, -8192, 100, 3};
      cfg_ratio = 2; cfg_mode = md;
      restart();
      vs = valid_seen;
      foreach (seq[i]) begin
        for (int g = 0; g < int'($urandom_range(0, 2)); g++) step(1, 0, 0, 0);
        step(1, 1, seq[i], -seq[i] - 1);
      end
      for (int g = 0; g < 3; g++) step(1, 0, 0, 0);
      check("gap_one_strobe", valid_seen - vs, 1);
      t14 = (md == 2) ? 14'd100 : 14'h2000;
      check("maxmin_ch0", out_data[DW-1:0], t14);
    end

    // Ratio change 2->3 mid-window: this window ends at 4, the next at 8.
    cfg_ratio = 2; cfg_mode = 0;
    restart();
    step(1, 1, 11, 12);
    step(1, 1, 13, 14);
    cfg_ratio = 3;
    step(1, 1, 15, 16);
    step(1, 1, 17, 18);
    check("cfgchg_first_end", out_valid, 1'b1);
    vs = valid_seen;
    for (int i = 0; i < 8; i++) step(1, 1, 20 + i, 30 + i);
    check("cfgchg_second_count", valid_seen - vs, 1);
    check("cfgchg_second_end", out_valid, 1'b1);

    // Clamp: ratio 15 behaves as 256-sample windows.
    cfg_ratio = 15; cfg_mode = 1;
    restart();
    vs = valid_seen;
    for (int i = 0; i < 255; i++) step(1, 1, $urandom, $urandom);
    check("clamp_no_early", valid_seen - vs, 0);
    step(1, 1, $urandom, $urandom);
    check("clamp_end", out_valid, 1'b1);

    // R=1 passthrough: strobe every cycle.
    cfg_ratio = 0; cfg_mode = 3;
    restart();
    for (int i = 0; i < 5; i++) begin
      v0 = $urandom;
      step(1, 1, v0, i);
      check("r1_strobe", out_valid, 1'b1);
    end

    // Abort: ena drops on the 4th sample; re-enable starts a fresh window.
    cfg_ratio = 2; cfg_mode = 0;
    restart();
    for (int i = 0; i < 4; i++) step(1, 1, 50 + i, 60 + i);
    for (int i = 0; i < 3; i++) step(1, 1, 70 + i, 80 + i);
    step(0, 1, 73, 83);
    check("abort_valid", out_valid, 1'b0);
    check("abort_data", out_data, '0);
    step(1, 1, 90, 91);
    for (int i = 0; i < 4; i++) step(1, 1, 40 + i, 41 + i);
    check("reenable_pick", out_data[DW-1:0], 14'd40);

    // Random traffic: occasional disables, config churn, sparse valids.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) cfg_ratio = $urandom_range(0, 10);
      if ($urandom_range(0, 15) == 0) cfg_mode = $urandom_range(0, 3);
      if (cfg_ratio > 4) cfg_ratio = $urandom_range(0, 4);
      step($urandom_range(0, 40) != 0, $urandom_range(0, 3) != 0, $urandom, $urandom);
    end

    // Asynchronous reset mid-window clears outputs without waiting for an edge.
    cfg_ratio = 1; cfg_mode = 0;
    restart();
    step(1, 1, 77, 78);
    step(1, 1, 1, 2);
    step(1, 1, 5, 6);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_valid", out_valid, 1'b0);
    check("async_data", out_data, '0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 0, 0, 0);
    step(1, 1, 33, 34);
    step(1, 1, 35, 36);
    check("post_reset_pick", out_data, {14'd34, 14'd33});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decimator.md
# decimator

Parametrised multi-channel decimator for the ADC capture path, successor to the fixed pick-one-in-2^n downsampler. Sits between ADC data capture and the stream/DA logic. Reduces each channel by a runtime-selectable power-of-two ratio. Selectable reduction modes: pick, average, max, min. Emits a single-cycle output strobe per window.

## Interface
- `DATAWIDTH`, 14, sample width per channel, signed two's complement
- `NUM_CH`, 2, number of parallel channels
- `MAX_LOG2`, 8, largest supported log2 decimation ratio
- `clk`  in  1  system clock; all logic on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `ena`  in  1  block enable; low = flush and hold idle
- `in_valid`  in  1  qualifies `in_data` this cycle
- `in_data`  in  NUM_CH*DATAWIDTH  channel k at bits [k*DATAWIDTH +: DATAWIDTH]
- `ratio_log2`  in  $clog2(MAX_LOG2+1)  decimation ratio R = 2^ratio_log2
- `mode`  in  2  0 pick, 1 average, 2 max, 3 min
- `out_valid`  out  1  one-cycle strobe, result valid
- `out_data`  out  NUM_CH*DATAWIDTH  decimated samples, same packing as input

## Operation
- FSM states: IDLE, RUN.
  - IDLE: entered on reset or when `ena`=0.
  - IDLE -> RUN on the first cycle with `ena`=1.
  - RUN -> IDLE whenever `ena`=0, including mid-window.
- In IDLE:
  - sample counter, accumulators and `out_valid` are 0.
  - `out_data` is cleared to 0.
- Window = R accepted samples, where an accepted sample is `in_valid`=1 while in RUN. Cycles with `in_valid`=0 do not advance the window.
- `ratio_log2` and `mode` are latched on the first accepted sample of each window. Changes mid-window take effect from the next window.
- `ratio_log2` > MAX_LOG2 is clamped to MAX_LOG2.
- Per channel, by mode:
  - pick: result = first sample of the window.
  - average:
    - Accumulator is DATAWIDTH+MAX_LOG2 bits, signed.
    - Result = sum >>> ratio_log2, arithmetic shift, truncation toward -inf.
    - No overflow is possible.
  - max / min: signed compare. The accumulator is seeded with the first sample of the window.
- R=1 (`ratio_log2`=0): every accepted sample is passed through, identical in all modes.
- Sample counter wraps to 0 after the last sample of a window. The next window starts immediately; no dead cycle.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, state IDLE, counter 0.
- Latency: `out_valid` pulses one cycle after the clock edge that accepts the R-th sample of a window. `out_data` updates on that same edge.
- `out_data` holds until the next `out_valid`. Exception: `ena`=0 clears it on the next edge.
- Max throughput: one accepted sample per cycle. With R=1 and continuous `in_valid`, `out_valid` is high every cycle.
- `ena` falling on the cycle that would complete a window: `ena` has priority. No `out_valid` is issued, and the partial window is discarded.
- `rst_n` asserted mid-window: outputs go to reset values immediately (async). No partial result is ever emitted.
- After `ena` rises, the first window starts at the first accepted sample.

## Structure
- Package `decim_pkg`:
  - mode encodings MODE_PICK=0, MODE_AVG=1, MODE_MAX=2, MODE_MIN=3
  - FSM state typedef
- Sub-module `decim_channel`, instantiated NUM_CH times via generate. Holds one channel's accumulator and compare logic and the result register.
- Top level holds the FSM, shared sample counter, config latch and `out_valid` generation.
- Target: roughly 200-300 lines RTL total.

## Test plan
- Reset/idle: hold `rst_n`=0, then `ena`=0 with random valid input -> `out_valid`=0 and `out_data`=0 throughout.
- Pick, R=4, NUM_CH=2:
  - Stimulus: ch0 ramps 0,1,2,... and ch1 ramps -1,-2,...
  - Response: outputs ch0=0,4,8 and ch1=-1,-5,-9.
  - Each `out_valid` is one cycle after every 4th accepted sample.
- Average, R=8: ch0 inputs 1..8 give `out_data`=4 (36>>>3); inputs -1 x8 give -1; 8191 x8 gives 8191 with no overflow.
- Max/min with gaps:
  - Stimulus: R=4, inputs 5,-8192,100,3, with `in_valid` gaps inserted between samples.
  - Max gives 100; min gives -8192.
  - Exactly one `out_valid` per window despite the gaps.
- Config change and clamp:
  - Change `ratio_log2` 2->3 mid-window -> the current window completes at 4 samples, the next at 8.
  - Set `ratio_log2`=15 with MAX_LOG2=8 -> windows of 256.
- Abort: drop `ena` on the cycle of the 4th sample (R=4) -> no `out_valid`, `out_data`=0. Re-enable -> the next window counts from a fresh first sample.
